// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txStateType;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/flex_counter.sv
// Up-counter running 1..rollover_val and wrapping back to 1; clear returns it to 0.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/uarttx_core.sv
// 8N1 UART transmitter with a one-byte holding buffer and valid/ready intake.
module uarttx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);

    txStateType  state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  shift_q, shift_d;

    logic        accept, load;
    logic        baud_clear, bit_clear, bit_en;
    logic        period_end, last_bit;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic        unused_cnt;

    // Baud counter reads 1 in the first cycle of every bit, so the load edge
    // out of IDLE counts too; it only sits at 0 while idling.
    flex_counter #(.NUM_CNT_BITS(BAUD_W)) u_baud_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (baud_clear),
        .count_enable (1'b1),
        .rollover_val (BAUD_W'(CLKS_PER_BIT)),
        .count_out    (baud_cnt),
        .rollover_flag(period_end)
    );

    // Bit counter holds index+1 during DATA, so its rollover marks bit 7.
    flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bit_clear),
        .count_enable (bit_en),
        .rollover_val (4'(UART_DATA_BITS)),
        .count_out    (bit_cnt),
        .rollover_flag(last_bit)
    );

    assign unused_cnt = ^{baud_cnt, bit_cnt};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        load       = 1'b0;
        baud_clear = 1'b0;
        bit_clear  = 1'b0;
        bit_en     = 1'b0;
        serial_out = STOP_BIT;
        tx_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end else begin
                    baud_clear = 1'b1;
                end
            end
            START: begin
                serial_out = START_BIT;
                if (period_end) begin
                    bit_en  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                serial_out = shift_q[0];
                if (period_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (last_bit) begin
                        state_d = STOP;
                    end else begin
                        bit_en = 1'b1;
                    end
                end
            end
            STOP: begin
                serial_out = STOP_BIT;
                if (period_end) begin
                    tx_done = 1'b1;
                    if (buf_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        baud_clear = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d   = buf_q;
            bit_clear = 1'b1;
        end
    end

    // A simultaneous accept wins over the load so the new byte stays queued.
    assign accept = tx_valid && !buf_full_q;

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            shift_q    <= shift_d;
        end
    end

    assign tx_ready = !buf_full_q;
    assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uarttx_core.sv
// Directed bench for uarttx_core at 10 and 2 clocks per bit.
module tb_uarttx_core;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, serial_out, tx_busy, tx_done;
    logic       tx_ready2, serial_out2, tx_busy2, tx_done2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uarttx_core #(.CLKS_PER_BIT(10)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    uarttx_core #(.CLKS_PER_BIT(2)) dut2 (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_data   (tx_data2),
        .tx_valid  (tx_valid2),
        .tx_ready  (tx_ready2),
        .serial_out(serial_out2),
        .tx_busy   (tx_busy2),
        .tx_done   (tx_done2)
    );

    // Packed observation order: {serial_out, tx_busy, tx_done, tx_ready}.
    function automatic logic [3:0] obs(input logic sel);
        return sel ? {serial_out2, tx_busy2, tx_done2, tx_ready2}
                   : {serial_out, tx_busy, tx_done, tx_ready};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Frame pattern bit j is the line level during bit period j (0 = start, 9 = stop).
    task automatic check_frame(input string tag, input logic [9:0] pat, input int cpb,
                               input int ks, input int ke, input logic exp_ready,
                               input logic sel);
        for (int k = ks; k <= ke; k++) begin
            logic [3:0] exp;
            exp = {pat[(k - 1) / cpb], 1'b1, (k == 10 * cpb), exp_ready};
            checks++;
            assert (obs(sel) === exp) else begin
                failures++;
                $error("FAIL %s cycle %0d: got %b expected %b", tag, k, obs(sel), exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a byte offered
        n_rst     = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'h11;
        tx_valid2 = 1'b1;
        tx_data2  = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut10", obs(1'b0), 4'b1001);
        chk("reset_dut2", obs(1'b1), 4'b1001);
        @(negedge clk);
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        n_rst     = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_dut10", obs(1'b0), 4'b1001);
        chk("post_reset_dut2", obs(1'b1), 4'b1001);

        // Single byte 0xA5 -> frame 10'h34A
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk); #1;
        chk("a5_accept", obs(1'b0), 4'b1000);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h5A;
        @(posedge clk); #1;
        check_frame("a5", 10'h34A, 10, 1, 100, 1'b1, 1'b0);
        chk("a5_idle", obs(1'b0), 4'b1001);
        @(posedge clk); #1;
        chk("a5_idle2", obs(1'b0), 4'b1001);

        // Back-to-back 0x00 (10'h200) then 0xFF (10'h3FE)
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        tx_data = 8'hFF;
        @(posedge clk); #1;
        check_frame("b2b_00", 10'h200, 10, 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame("b2b_00", 10'h200, 10, 2, 100, 1'b0, 1'b0);
        check_frame("b2b_ff", 10'h3FE, 10, 1, 100, 1'b1, 1'b0);
        chk("b2b_idle", obs(1'b0), 4'b1001);

        // Collision: 0x3C offered on the edge that loads 0x81 (10'h302), after 0xC3 (10'h386)
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(posedge clk); #1;
        @(negedge clk);
        tx_data = 8'h81;
        @(posedge clk); #1;
        check_frame("col_c3", 10'h386, 10, 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hEE;
        check_frame("col_c3", 10'h386, 10, 2, 99, 1'b0, 1'b0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        check_frame("col_c3", 10'h386, 10, 100, 100, 1'b0, 1'b0);
        check_frame("col_81", 10'h302, 10, 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hEE;
        check_frame("col_81", 10'h302, 10, 2, 100, 1'b0, 1'b0);
        check_frame("col_3c", 10'h278, 10, 1, 100, 1'b1, 1'b0);
        chk("col_idle", obs(1'b0), 4'b1001);

        // Reset during data bit 4 of 0x0F (10'h21E)
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h0F;
        @(posedge clk); #1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(posedge clk); #1;
        check_frame("rst_0f", 10'h21E, 10, 1, 55, 1'b1, 1'b0);
        chk("rst_bit4_low", obs(1'b0), 4'b0101);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_async", obs(1'b0), 4'b1001);
        @(posedge clk); #1;
        chk("rst_held", obs(1'b0), 4'b1001);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_release_%0d", i), obs(1'b0), 4'b1001);
        end

        // Minimum rate: 0x55 at 2 clocks per bit (10'h2AA)
        @(negedge clk);
        tx_valid2 = 1'b1;
        tx_data2  = 8'h55;
        @(posedge clk); #1;
        chk("min_accept", obs(1'b1), 4'b1000);
        @(negedge clk);
        tx_valid2 = 1'b0;
        @(posedge clk); #1;
        check_frame("min_55", 10'h2AA, 2, 1, 20, 1'b1, 1'b1);
        chk("min_idle", obs(1'b1), 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
